// File: rtl/maze_packet_rx_pkg.sv
// Shared definitions for the maze packet receiver: FSM encoding, tile-word
// field positions and frame lengths.
// Build option: MAZE_PACKET_RX_PARITY_EN selects 17-bit frames with odd parity.
package maze_packet_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Tile word layout {y, x, tile}
    localparam int unsigned Y_MSB = 15;
    localparam int unsigned Y_LSB = 14;
    localparam int unsigned X_MSB = 13;
    localparam int unsigned X_LSB = 11;

    localparam logic [4:0] FRAME_LEN_DATA   = 5'd16;
    localparam logic [4:0] FRAME_LEN_PARITY = 5'd17;

`ifdef MAZE_PACKET_RX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam logic [4:0]  FRAME_LEN = PARITY_EN ? FRAME_LEN_PARITY : FRAME_LEN_DATA;
    localparam int unsigned SHREG_W   = PARITY_EN ? 17 : 16;

endpackage

// File: rtl/maze_packet_rx_sync2.sv
// Two-flop synchronizer with asynchronous reset to a configurable idle level.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic dout
);

    logic meta;

    // Resample the asynchronous input twice into the CLK domain
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta <= RST_VAL;
            dout <= RST_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/maze_packet_rx.sv
// Serial tile-word receiver for frames sent by the Arduino over a
// CS/CLK/DATA link, MSB first. Valid words are presented on DATA_OUT with a
// one-cycle DATA_VAL pulse; bad frames give a FRAME_ERR pulse.
// Build option: MAZE_PACKET_RX_PARITY_EN (17-bit frames, odd parity in last bit).
module maze_packet_rx
    import maze_packet_rx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned MAZE_X_MAX     = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SER_CS,
    input  logic        SER_CLK,
    input  logic        SER_DATA,
    output logic [15:0] DATA_OUT,
    output logic        DATA_VAL,
    output logic        FRAME_ERR,
    output logic [7:0]  PKT_COUNT,
    output logic [7:0]  ERR_COUNT
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic cs_s, clk_s, data_s;
    logic cs_d, clk_d, data_d;
    logic cs_rise_q, cs_fall_q, clk_rise_q, clk_edge_q;
    logic [1:0] warm;
    logic cs_armed;

    state_t               state;
    logic [4:0]           bit_cnt;
    logic [SHREG_W-1:0]   shreg;
    logic [TW-1:0]        timer;
    logic [15:0]          rx_word;
    logic                 frame_ok;

    sync2 #(.RST_VAL(1'b1)) u_sync_cs (
        .CLK(CLK), .RESET(RESET), .din(SER_CS), .dout(cs_s)
    );
    sync2 #(.RST_VAL(1'b0)) u_sync_clk (
        .CLK(CLK), .RESET(RESET), .din(SER_CLK), .dout(clk_s)
    );
    sync2 #(.RST_VAL(1'b0)) u_sync_data (
        .CLK(CLK), .RESET(RESET), .din(SER_DATA), .dout(data_s)
    );

    // Registered edge pulses; data is delayed alongside so it lines up with clk_rise_q.
    // CS falls are only honoured once CS has been seen high after reset, so a CS
    // held low across reset release is not mistaken for a new frame start.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cs_d       <= 1'b1;
            clk_d      <= 1'b0;
            data_d     <= 1'b0;
            cs_rise_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
            clk_rise_q <= 1'b0;
            clk_edge_q <= 1'b0;
            warm       <= '0;
            cs_armed   <= 1'b0;
        end else begin
            cs_d       <= cs_s;
            clk_d      <= clk_s;
            data_d     <= data_s;
            cs_rise_q  <= cs_s & ~cs_d;
            cs_fall_q  <= ~cs_s & cs_d & cs_armed;
            clk_rise_q <= clk_s & ~clk_d;
            clk_edge_q <= clk_s ^ clk_d;
            warm       <= {warm[0], 1'b1};
            cs_armed   <= cs_armed | (warm[1] & cs_s);
        end
    end

    // Frame validation: length, x range and (optionally) odd parity
    always_comb begin
        rx_word  = '0;
        frame_ok = 1'b0;
`ifdef MAZE_PACKET_RX_PARITY_EN
        rx_word  = shreg[16:1];
        frame_ok = (bit_cnt == FRAME_LEN)
                && ({29'd0, rx_word[X_MSB:X_LSB]} < MAZE_X_MAX)
                && (^shreg);
`else
        rx_word  = shreg;
        frame_ok = (bit_cnt == FRAME_LEN)
                && ({29'd0, rx_word[X_MSB:X_LSB]} < MAZE_X_MAX);
`endif
    end

    // Receive FSM with registered outputs and counters
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            timer     <= '0;
            DATA_OUT  <= '0;
            DATA_VAL  <= 1'b0;
            FRAME_ERR <= 1'b0;
            PKT_COUNT <= '0;
            ERR_COUNT <= '0;
        end else begin
            DATA_VAL  <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall_q) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        shreg   <= '0;
                        timer   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise_q) begin
                        // a SER_CLK edge coinciding with CS release is dropped here
                        state <= ST_CHECK;
                    end else if (timer == TMO_LAST) begin
                        state     <= ST_IDLE;
                        FRAME_ERR <= 1'b1;
                        if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + 1'b1;
                    end else begin
                        if (clk_rise_q) begin
                            shreg <= {shreg[SHREG_W-2:0], data_d};
                            if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (clk_edge_q) timer <= '0;
                        else            timer <= timer + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state <= ST_IDLE;
                    if (frame_ok) begin
                        DATA_OUT  <= {rx_word[Y_MSB:Y_LSB], rx_word[X_MSB:X_LSB],
                                      rx_word[X_LSB-1:0]};
                        DATA_VAL  <= 1'b1;
                        PKT_COUNT <= PKT_COUNT + 1'b1;
                    end else begin
                        FRAME_ERR <= 1'b1;
                        if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_packet_rx.sv
// Directed bench for maze_packet_rx: a table of frames with hand-computed
// results plus sequences for timeout, CS/CLK coincidence and mid-frame reset.
module tb_maze_packet_rx;

    localparam int unsigned T_OUT = 40;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SER_CS = 1'b1;
    logic        SER_CLK = 1'b0;
    logic        SER_DATA = 1'b0;
    logic [15:0] DATA_OUT;
    logic        DATA_VAL;
    logic        FRAME_ERR;
    logic [7:0]  PKT_COUNT;
    logic [7:0]  ERR_COUNT;

    maze_packet_rx #(.TIMEOUT_CYCLES(T_OUT), .MAZE_X_MAX(5)) dut (
        .CLK(CLK), .RESET(RESET), .SER_CS(SER_CS), .SER_CLK(SER_CLK),
        .SER_DATA(SER_DATA), .DATA_OUT(DATA_OUT), .DATA_VAL(DATA_VAL),
        .FRAME_ERR(FRAME_ERR), .PKT_COUNT(PKT_COUNT), .ERR_COUNT(ERR_COUNT)
    );

    always #10 CLK = ~CLK;

    int cyc = 0;
    int dv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int dv_cyc = 0, fe_cyc = 0;
    int rise_cyc = 0, last_fall_cyc = 0;
    int n_tests = 0, n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (DATA_VAL)  begin dv_cnt++; dv_cyc = cyc; end
        if (FRAME_ERR) begin fe_cnt++; fe_cyc = cyc; end
        if (DATA_VAL && FRAME_ERR) both_cnt++;
    end

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        logic        ok;
        logic [15:0] exp_data;
        logic [7:0]  exp_pkt;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs[10];

`ifdef MAZE_PACKET_RX_PARITY_EN
    localparam int FL = 17;
    function automatic logic [31:0] f16(input logic [15:0] d);
        return {15'd0, d, ~^d};
    endfunction
`else
    localparam int FL = 16;
    function automatic logic [31:0] f16(input logic [15:0] d);
        return {16'd0, d};
    endfunction
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drop CS and clock out n bits MSB first; CS is left low, SER_CLK low
    task automatic send_bits(input logic [31:0] bits, input int n);
        @(negedge CLK);
        SER_CS = 1'b0;
        repeat (3) @(negedge CLK);
        for (int i = n - 1; i >= 0; i--) begin
            SER_DATA = bits[i];
            @(negedge CLK);
            SER_CLK = 1'b1;
            repeat (2) @(negedge CLK);
            SER_CLK = 1'b0;
            last_fall_cyc = cyc;
            @(negedge CLK);
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n);
        send_bits(bits, n);
        SER_CS = 1'b1;
        rise_cyc = cyc;
        repeat (12) @(negedge CLK);
    endtask

    initial begin
        #1_800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dv0, fe0;
        logic [31:0] bad17;
`ifdef MAZE_PACKET_RX_PARITY_EN
        bad17 = 32'h3;        // 0x0001 with parity bit 1 (even total)
`else
        bad17 = 32'h9;        // 17-bit frame: length error
`endif
        vecs[0] = '{f16(16'h4A55), FL, 1'b1, 16'h4A55, 8'd1, 8'd0};
        vecs[1] = '{f16(16'h2A00), FL, 1'b0, 16'h4A55, 8'd1, 8'd1};
        vecs[2] = '{32'h1234,      15, 1'b0, 16'h4A55, 8'd1, 8'd2};
        vecs[3] = '{32'h4A55F,     20, 1'b0, 16'h4A55, 8'd1, 8'd3};
        vecs[4] = '{bad17,         17, 1'b0, 16'h4A55, 8'd1, 8'd4};
        vecs[5] = '{f16(16'h0004), FL, 1'b1, 16'h0004, 8'd2, 8'd4};
        vecs[6] = '{f16(16'h2000), FL, 1'b1, 16'h2000, 8'd3, 8'd4};
        vecs[7] = '{f16(16'h3800), FL, 1'b0, 16'h2000, 8'd3, 8'd5};
        vecs[8] = '{f16(16'hC7FF), FL, 1'b1, 16'hC7FF, 8'd4, 8'd5};
        vecs[9] = '{f16(16'h0001), FL, 1'b1, 16'h0001, 8'd5, 8'd5};

        repeat (4) @(negedge CLK);
        check("reset DATA_OUT", 32'(DATA_OUT), 32'h0);
        check("reset DATA_VAL", 32'(DATA_VAL), 32'h0);
        check("reset FRAME_ERR", 32'(FRAME_ERR), 32'h0);
        check("reset PKT_COUNT", 32'(PKT_COUNT), 32'h0);
        check("reset ERR_COUNT", 32'(ERR_COUNT), 32'h0);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);

        for (int v = 0; v < 10; v++) begin
            dv0 = dv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[v].bits, vecs[v].nbits);
            check($sformatf("vec%0d DATA_VAL pulses", v), 32'(dv_cnt - dv0), 32'(vecs[v].ok));
            check($sformatf("vec%0d FRAME_ERR pulses", v), 32'(fe_cnt - fe0), 32'(!vecs[v].ok));
            check($sformatf("vec%0d DATA_OUT", v), 32'(DATA_OUT), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d PKT_COUNT", v), 32'(PKT_COUNT), 32'(vecs[v].exp_pkt));
            check($sformatf("vec%0d ERR_COUNT", v), 32'(ERR_COUNT), 32'(vecs[v].exp_err));
            if (vecs[v].ok)
                check($sformatf("vec%0d DATA_VAL latency", v), 32'(dv_cyc - rise_cyc), 32'd5);
        end

        // SER_CLK edge in the same cycle as CS release, then SER_CLK activity in IDLE
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_bits(f16(16'h4A55), FL);
        SER_CS = 1'b1;
        SER_CLK = 1'b1;
        repeat (12) @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            SER_CLK = ~SER_CLK;
            repeat (3) @(negedge CLK);
        end
        SER_CLK = 1'b0;
        repeat (6) @(negedge CLK);
        check("coincident edge DATA_VAL pulses", 32'(dv_cnt - dv0), 32'd1);
        check("coincident edge FRAME_ERR pulses", 32'(fe_cnt - fe0), 32'd0);
        check("coincident edge DATA_OUT", 32'(DATA_OUT), 32'h4A55);
        check("coincident edge PKT_COUNT", 32'(PKT_COUNT), 32'd6);

        // Timeout: 8 bits then SER_CLK stops with CS low
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_bits(32'hA5, 8);
        for (int k = 0; k < int'(T_OUT) + 60 && fe_cnt == fe0; k++) @(negedge CLK);
        check("timeout FRAME_ERR pulses", 32'(fe_cnt - fe0), 32'd1);
        check("timeout latency", 32'(fe_cyc - last_fall_cyc), 32'(T_OUT + 4));
        check("timeout ERR_COUNT", 32'(ERR_COUNT), 32'd6);
        SER_CS = 1'b1;
        repeat (12) @(negedge CLK);
        check("timeout no extra FRAME_ERR", 32'(fe_cnt - fe0), 32'd1);
        check("timeout no DATA_VAL", 32'(dv_cnt - dv0), 32'd0);
        send_frame(f16(16'h0800), FL);
        check("after timeout DATA_OUT", 32'(DATA_OUT), 32'h0800);
        check("after timeout PKT_COUNT", 32'(PKT_COUNT), 32'd7);

        // Reset after bit 10, CS held low across release
        send_bits(f16(16'h4A55), 10);
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check("mid-frame reset DATA_OUT", 32'(DATA_OUT), 32'h0);
        check("mid-frame reset PKT_COUNT", 32'(PKT_COUNT), 32'h0);
        check("mid-frame reset ERR_COUNT", 32'(ERR_COUNT), 32'h0);
        RESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (2) @(negedge CLK);
            SER_CLK = 1'b1;
            repeat (2) @(negedge CLK);
            SER_CLK = 1'b0;
        end
        repeat (2) @(negedge CLK);
        SER_CS = 1'b1;
        repeat (12) @(negedge CLK);
        check("reset no DATA_VAL", 32'(dv_cnt - dv0), 32'd0);
        check("reset no FRAME_ERR", 32'(fe_cnt - fe0), 32'd0);
        send_frame(f16(16'h0004), FL);
        check("post-reset DATA_OUT", 32'(DATA_OUT), 32'h0004);
        check("post-reset PKT_COUNT", 32'(PKT_COUNT), 32'd1);
        check("post-reset ERR_COUNT", 32'(ERR_COUNT), 32'd0);

        // PKT_COUNT wrap: 300 good frames in total -> 300 mod 256 = 44
        for (int k = 0; k < 299; k++) send_frame(f16(16'h0004), FL);
        check("wrap PKT_COUNT", 32'(PKT_COUNT), 32'd44);
        check("wrap ERR_COUNT", 32'(ERR_COUNT), 32'd0);

        check("DATA_VAL and FRAME_ERR never together", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
